// File: rtl/imm_seq_pkg.sv
// Shared types, opcode/ALU constants and the opcode decoder for the
// immediate-ALU sequencer. Optional feature macro: IMM_SEQ_SINGLE_STEP_EN.
package imm_seq_pkg;

`ifdef IMM_SEQ_SINGLE_STEP_EN
  typedef enum logic [3:0] {
    S_IDLE,
    S_T0,
    S_T1,
    S_T2,
    S_T3,
    S_T4,
    S_T5,
    S_HALT,
    S_STEPWAIT
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE,
    S_T0,
    S_T1,
    S_T2,
    S_T3,
    S_T4,
    S_T5,
    S_HALT
  } state_t;
`endif

  localparam logic [4:0] OPC_ADDI = 5'b01100;
  localparam logic [4:0] OPC_ANDI = 5'b01101;
  localparam logic [4:0] OPC_ORI  = 5'b01110;

  localparam logic [4:0] ALU_ADD = 5'b00011;
  localparam logic [4:0] ALU_AND = 5'b00101;
  localparam logic [4:0] ALU_OR  = 5'b00110;

  localparam logic [1:0] FLT_NONE    = 2'b00;
  localparam logic [1:0] FLT_ILLEGAL = 2'b01;
  localparam logic [1:0] FLT_MEM_TO  = 2'b10;

  // Returns {legal, alu_control}; illegal opcodes yield a zero ALU op.
  function automatic logic [5:0] decode_opc(input logic [4:0] opc);
    logic [5:0] r;
    r = 6'b0;
    case (opc)
      OPC_ADDI: r = {1'b1, ALU_ADD};
      OPC_ANDI: r = {1'b1, ALU_AND};
      OPC_ORI:  r = {1'b1, ALU_OR};
      default:  r = 6'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/imm_alu_sequencer_timeout.sv
// T1 memory wait counter: restarts in T0, counts stalled T1 cycles and
// flags the last permitted stall cycle.
module imm_seq_timeout
  import imm_seq_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clock,
  input  logic clear,
  input  logic restart,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(MEM_TIMEOUT - 1);

  logic [CW-1:0] count;

  // Expired on the stalled cycle that would take the count to MEM_TIMEOUT.
  assign expired = enable && (count == LAST);

  // Count stalled cycles; hold once expired since the FSM leaves T1.
  always_ff @(posedge clock) begin
    if (!clear) begin
      count <= '0;
    end else if (restart) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/imm_alu_sequencer.sv
// Fetch/execute control sequencer for ADDI/ANDI/ORI with mem-ready timeout,
// illegal-opcode trap and run/halt. Optional macro: IMM_SEQ_SINGLE_STEP_EN.
module imm_alu_sequencer
  import imm_seq_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int OPC_W       = 5,
  parameter int ALU_W       = 5,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              run,
  input  logic              mem_ready,
`ifdef IMM_SEQ_SINGLE_STEP_EN
  input  logic              step,
`endif
  input  logic [DATA_W-1:0] ir,
  output logic              pc_out,
  output logic              inc_pc,
  output logic              mar_in,
  output logic              read,
  output logic              ram_enable,
  output logic              mdr_in,
  output logic              mdr_out,
  output logic              ir_in,
  output logic              grb,
  output logic              rout,
  output logic              yin,
  output logic              cout,
  output logic              zlo_in,
  output logic [ALU_W-1:0]  alu_control,
  output logic              zmux_enable,
  output logic              zmux_out,
  output logic              gra,
  output logic              rin,
  output logic              busy,
  output logic              retired,
  output logic [1:0]        fault
);

  state_t           state;
  logic             expired;
  logic [OPC_W-1:0] opc;
  logic [5:0]       dec;
  logic             unused_ir;

  assign opc       = ir[DATA_W-1 -: OPC_W];
  assign dec       = decode_opc(opc);
  assign unused_ir = ^ir[DATA_W-OPC_W-1:0];

  imm_seq_timeout #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_timeout (
    .clock   (clock),
    .clear   (clear),
    .restart (state == S_T0),
    .enable  ((state == S_T1) && !mem_ready),
    .expired (expired)
  );

`ifdef IMM_SEQ_SINGLE_STEP_EN
  logic step_q;

  // Previous step level for rising-edge detection.
  always_ff @(posedge clock) begin
    if (!clear) step_q <= 1'b0;
    else        step_q <= step;
  end
`endif

  // Main sequencer: state, sticky fault and the latched ALU operation.
  always_ff @(posedge clock) begin
    if (!clear) begin
      state       <= S_IDLE;
      fault       <= FLT_NONE;
      alu_control <= '0;
    end else begin
      case (state)
        S_IDLE: if (run) state <= S_T0;
        S_T0:   state <= S_T1;
        S_T1: begin
          if (mem_ready) begin
            state <= S_T2;
          end else if (expired) begin
            state <= S_HALT;
            fault <= FLT_MEM_TO;
          end
        end
        S_T2:   state <= S_T3;
        S_T3: begin
          if (dec[5]) begin
            alu_control <= dec[ALU_W-1:0];
            state       <= S_T4;
          end else begin
            state <= S_HALT;
            fault <= FLT_ILLEGAL;
          end
        end
        S_T4:   state <= S_T5;
`ifdef IMM_SEQ_SINGLE_STEP_EN
        S_T5:   state <= S_STEPWAIT;
        S_STEPWAIT: begin
          if (step && !step_q) begin
            if (run) begin
              state <= S_T0;
            end else begin
              state       <= S_IDLE;
              alu_control <= '0;
            end
          end
        end
`else
        S_T5: begin
          if (run) begin
            state <= S_T0;
          end else begin
            state       <= S_IDLE;
            alu_control <= '0;
          end
        end
`endif
        S_HALT: state <= S_HALT;
        default: begin
          state       <= S_IDLE;
          alu_control <= '0;
        end
      endcase
    end
  end

  assign pc_out      = (state == S_T0);
  assign inc_pc      = (state == S_T0);
  assign mar_in      = (state == S_T0);
  assign read        = (state == S_T1);
  assign ram_enable  = (state == S_T1);
  assign mdr_in      = (state == S_T1);
  assign mdr_out     = (state == S_T2);
  assign ir_in       = (state == S_T2);
  assign grb         = (state == S_T3);
  assign rout        = (state == S_T3);
  assign yin         = (state == S_T3);
  assign cout        = (state == S_T4);
  assign zlo_in      = (state == S_T4);
  assign zmux_enable = (state == S_T5);
  assign zmux_out    = (state == S_T5);
  assign gra         = (state == S_T5);
  assign rin         = (state == S_T5);
  assign retired     = (state == S_T5);
`ifdef IMM_SEQ_SINGLE_STEP_EN
  assign busy = !(state inside {S_IDLE, S_HALT, S_STEPWAIT});
`else
  assign busy = !(state inside {S_IDLE, S_HALT});
`endif

endmodule
